kuznechik_l_transform: RTL

Iterative GOST R 34.12-2015 (Kuznechik) linear transform L = R^16 and its inverse L^-1, applied to one 128-bit block. It sits directly downstream of the S-box stage and upstream of the round-key XOR in each round. It reuses the per-constant GF(2^8) multiplier tables, including the multiply-by-148 table. The block computes UNROLL R-steps per clock and uses valid/ready handshakes on both sides.

---
 rtl/kuznechik_l_transform.sv | 121 ++++++++++++
 1 files changed

// File: rtl/kuznechik_l_transform.sv
// Kuznechik linear transform L = R^16 and its inverse, computed iteratively with UNROLL
// R-steps per clock behind valid/ready handshakes on both sides.
module kuznechik_l_transform #(
  parameter int unsigned UNROLL = 1  // legal: 1, 2, 4, 8, 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  // Coefficient for byte a_i sits at bits [8*i +: 8]; a15 is the top byte.
  localparam logic [127:0] LinCoef = 128'h94_20_85_10_c2_c0_01_fb_01_c0_c2_10_85_20_94_01;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic         inv_q, inv_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [4:0]   cnt_sum;
  logic [127:0] stepped;

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1; constant operands fold into fixed tables.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] p;
    x = a;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hc3 : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] l_func(input logic [127:0] s);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      acc = acc ^ gf_mul(s[8*i +: 8], LinCoef[8*i +: 8]);
    end
    return acc;
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] s);
    return {l_func(s), s[127:8]};
  endfunction

  // Rotating a15 into the a0 slot lets the forward coefficient vector serve the inverse.
  function automatic logic [127:0] inv_step(input logic [127:0] s);
    logic [127:0] v;
    v = {s[119:0], s[127:120]};
    return {s[119:0], l_func(v)};
  endfunction

  always_comb begin
    stepped = state_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      stepped = inv_q ? inv_step(stepped) : fwd_step(stepped);
    end
  end

  assign cnt_sum = cnt_q + 5'(UNROLL);

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (fsm_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        busy    = 1'b1;
        state_d = stepped;
        cnt_d   = cnt_sum;
        if (cnt_sum == 5'd16) fsm_d = StDone;
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = state_q;
        if (out_ready) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
